// File: rtl/rl_ram_1r1w_pipe.sv
// Simple dual-port RAM: one write port with byte lanes, one pipelined read port.
// Read-during-write behaviour and read latency are set by parameters.
module rl_ram_1r1w_pipe #(
   parameter int    ABITS      = 10,
   parameter int    DBITS      = 32,
   parameter int    BBITS      = 8,
   parameter int    DEPTH      = 2**ABITS,
   parameter int    RD_LATENCY = 1,
   parameter int    BYPASS     = 1,
   parameter string INIT_FILE  = ""
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [ABITS-1:0]                   waddr_i,
   input  logic [DBITS-1:0]                   din_i,
   input  logic                               we_i,
   input  logic [(DBITS+BBITS-1)/BBITS-1:0]   be_i,
   input  logic [ABITS-1:0]                   raddr_i,
   input  logic                               re_i,
   output logic [DBITS-1:0]                   dout_o,
   output logic                               dvalid_o,
   output logic                               rerr_o,
   output logic                               werr_o
);

   localparam int NB = (DBITS+BBITS-1)/BBITS;
   localparam logic [ABITS:0] DEPTH_L = (ABITS+1)'(DEPTH);

   logic [DBITS-1:0] mem [DEPTH];

   logic             wrInRange;
   logic             rdInRange;
   logic             wrEn;
   logic             wrHit;
   logic [DBITS-1:0] laneMask;
   logic [DBITS-1:0] wrOld;
   logic [DBITS-1:0] wrWord;
   logic [DBITS-1:0] rdWord;

   logic             s1Valid_q, s1Valid_d;
   logic             s1Err_q,   s1Err_d;
   logic [DBITS-1:0] s1Data_q,  s1Data_d;
   logic             werr_q,    werr_d;

   // Lane enables expanded to a bit mask; a narrower top lane falls out of the bit loop.
   always_comb begin
      laneMask = '0;
      for (int b = 0; b < DBITS; b++) begin
         laneMask[b] = be_i[b/BBITS];
      end
   end

   // Write merge and read/bypass word formation.
   always_comb begin
      wrInRange = ({1'b0, waddr_i} < DEPTH_L);
      rdInRange = ({1'b0, raddr_i} < DEPTH_L);
      wrEn      = we_i && !rst_i && wrInRange && (|be_i);
      wrHit     = wrEn && (waddr_i == raddr_i);
      wrOld     = wrInRange ? mem[waddr_i] : '0;
      wrWord    = (wrOld & ~laneMask) | (din_i & laneMask);
      rdWord    = rdInRange ? mem[raddr_i] : '0;
      if ((BYPASS != 0) && wrHit) begin
         rdWord = (rdWord & ~laneMask) | (din_i & laneMask);
      end
   end

   // Storage itself is never reset so contents survive rst_i.
   always_ff @(posedge clk_i) begin
      if (wrEn) begin
         mem[waddr_i] <= wrWord;
      end
   end

   always_comb begin
      s1Valid_d = re_i;
      s1Err_d   = re_i && !rdInRange;
      s1Data_d  = s1Data_q;
      if (re_i) begin
         s1Data_d = rdInRange ? rdWord : '0;
      end
      werr_d = we_i && (|be_i) && !wrInRange;
   end

   // First read stage captures data at the sampling edge, decoupling it from later writes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1Valid_q <= 1'b0;
         s1Err_q   <= 1'b0;
         s1Data_q  <= '0;
         werr_q    <= 1'b0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s1Err_q   <= s1Err_d;
         s1Data_q  <= s1Data_d;
         werr_q    <= werr_d;
      end
   end

   assign werr_o = werr_q;

   if (RD_LATENCY == 2) begin : gLat2
      logic             s2Valid_q, s2Valid_d;
      logic             s2Err_q,   s2Err_d;
      logic [DBITS-1:0] s2Data_q,  s2Data_d;

      always_comb begin
         s2Valid_d = s1Valid_q;
         s2Err_d   = s1Err_q;
         s2Data_d  = s1Valid_q ? s1Data_q : s2Data_q;
      end

      // Second stage holds the last delivered word between results.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            s2Valid_q <= 1'b0;
            s2Err_q   <= 1'b0;
            s2Data_q  <= '0;
         end else begin
            s2Valid_q <= s2Valid_d;
            s2Err_q   <= s2Err_d;
            s2Data_q  <= s2Data_d;
         end
      end

      assign dout_o   = s2Data_q;
      assign dvalid_o = s2Valid_q;
      assign rerr_o   = s2Err_q;
   end else begin : gLat1
      assign dout_o   = s1Data_q;
      assign dvalid_o = s1Valid_q;
      assign rerr_o   = s1Err_q;
   end

endmodule

// File: tb/tb_rl_ram_1r1w_pipe.sv
// Directed bench: instance A is latency 1 / new-data bypass, instance B is
// latency 2 / old-data bypass; both share stimulus and DEPTH=1000.
module tb_rl_ram_1r1w_pipe;

   logic        clk;
   logic        rst;
   logic [9:0]  waddr;
   logic [31:0] din;
   logic        we;
   logic [3:0]  be;
   logic [9:0]  raddr;
   logic        re;

   logic [31:0] doutA, doutB;
   logic        dvalidA, dvalidB, rerrA, rerrB, werrA, werrB;

   int checks = 0;
   int errors = 0;

   rl_ram_1r1w_pipe #(
      .ABITS(10), .DBITS(32), .BBITS(8), .DEPTH(1000),
      .RD_LATENCY(1), .BYPASS(1), .INIT_FILE("")
   ) dutA (
      .clk_i(clk), .rst_i(rst), .waddr_i(waddr), .din_i(din), .we_i(we),
      .be_i(be), .raddr_i(raddr), .re_i(re), .dout_o(doutA),
      .dvalid_o(dvalidA), .rerr_o(rerrA), .werr_o(werrA)
   );

   rl_ram_1r1w_pipe #(
      .ABITS(10), .DBITS(32), .BBITS(8), .DEPTH(1000),
      .RD_LATENCY(2), .BYPASS(0), .INIT_FILE("")
   ) dutB (
      .clk_i(clk), .rst_i(rst), .waddr_i(waddr), .din_i(din), .we_i(we),
      .be_i(be), .raddr_i(raddr), .re_i(re), .dout_o(doutB),
      .dvalid_o(dvalidB), .rerr_o(rerrB), .werr_o(werrB)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge, then settle 1ns so outputs are sampled off the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic w, input logic [9:0] wa, input logic [31:0] d,
                                input logic [3:0] b, input logic r, input logic [9:0] ra);
      we = w; waddr = wa; din = d; be = b; re = r; raddr = ra;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      checks++;
      if ({dvalidA, rerrA, werrA, doutA} !== 35'h0) begin
         errors++;
         $display("[TB] FAIL reset_A got %h want %h", {dvalidA, rerrA, werrA, doutA}, 35'h0);
      end
      checks++;
      if ({dvalidB, rerrB, werrB, doutB} !== 35'h0) begin
         errors++;
         $display("[TB] FAIL reset_B got %h want %h", {dvalidB, rerrB, werrB, doutB}, 35'h0);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      applyStimulus(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 1'b0, 10'd0);
      tick();
      applyStimulus(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd5);
      tick();
      checks++;
      if ({dvalidA, rerrA, doutA} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL rd5_A got %h want %h", {dvalidA, rerrA, doutA}, {1'b1, 1'b0, 32'hDEADBEEF});
      end
      checks++;
      if (dvalidB !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd5_B_early dvalid got %b want 0", dvalidB);
      end
      idle();
      tick();
      checks++;
      if ({dvalidA, rerrA, doutA} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL hold_A got %h want %h", {dvalidA, rerrA, doutA}, {1'b0, 1'b0, 32'hDEADBEEF});
      end
      checks++;
      if ({dvalidB, rerrB, doutB} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL rd5_B got %h want %h", {dvalidB, rerrB, doutB}, {1'b1, 1'b0, 32'hDEADBEEF});
      end
      tick();
      checks++;
      if ({dvalidB, rerrB, doutB} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL hold_B got %h want %h", {dvalidB, rerrB, doutB}, {1'b0, 1'b0, 32'hDEADBEEF});
      end
   endtask

   task automatic test_byte_lanes();
      applyStimulus(1'b1, 10'd3, 32'h11223344, 4'hF, 1'b0, 10'd0);
      tick();
      applyStimulus(1'b1, 10'd3, 32'hAABBCCDD, 4'h5, 1'b0, 10'd0);
      tick();
      applyStimulus(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd3);
      tick();
      checks++;
      if ({dvalidA, doutA} !== {1'b1, 32'h11BB33DD}) begin
         errors++;
         $display("[TB] FAIL lanes_A got %h want %h", {dvalidA, doutA}, {1'b1, 32'h11BB33DD});
      end
      idle();
      tick();
      checks++;
      if ({dvalidB, doutB} !== {1'b1, 32'h11BB33DD}) begin
         errors++;
         $display("[TB] FAIL lanes_B got %h want %h", {dvalidB, doutB}, {1'b1, 32'h11BB33DD});
      end
   endtask

   task automatic test_bypass();
      applyStimulus(1'b1, 10'd7, 32'h00000000, 4'hF, 1'b0, 10'd0);
      tick();
      applyStimulus(1'b1, 10'd7, 32'hCAFEF00D, 4'hF, 1'b1, 10'd7);
      tick();
      checks++;
      if ({dvalidA, doutA} !== {1'b1, 32'hCAFEF00D}) begin
         errors++;
         $display("[TB] FAIL bypass_new_A got %h want %h", {dvalidA, doutA}, {1'b1, 32'hCAFEF00D});
      end
      idle();
      tick();
      checks++;
      if ({dvalidB, doutB} !== {1'b1, 32'h00000000}) begin
         errors++;
         $display("[TB] FAIL bypass_old_B got %h want %h", {dvalidB, doutB}, {1'b1, 32'h00000000});
      end
      // Partial-lane collision: word 7 is now CAFEF00D, low two lanes rewritten.
      applyStimulus(1'b1, 10'd7, 32'h12345678, 4'h3, 1'b1, 10'd7);
      tick();
      checks++;
      if ({dvalidA, doutA} !== {1'b1, 32'hCAFE5678}) begin
         errors++;
         $display("[TB] FAIL bypass_part_A got %h want %h", {dvalidA, doutA}, {1'b1, 32'hCAFE5678});
      end
      idle();
      tick();
      checks++;
      if ({dvalidB, doutB} !== {1'b1, 32'hCAFEF00D}) begin
         errors++;
         $display("[TB] FAIL bypass_part_B got %h want %h", {dvalidB, doutB}, {1'b1, 32'hCAFEF00D});
      end
      applyStimulus(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd7);
      tick();
      checks++;
      if ({dvalidA, doutA} !== {1'b1, 32'hCAFE5678}) begin
         errors++;
         $display("[TB] FAIL after_part_A got %h want %h", {dvalidA, doutA}, {1'b1, 32'hCAFE5678});
      end
      idle();
      tick();
      checks++;
      if ({dvalidB, doutB} !== {1'b1, 32'hCAFE5678}) begin
         errors++;
         $display("[TB] FAIL after_part_B got %h want %h", {dvalidB, doutB}, {1'b1, 32'hCAFE5678});
      end
   endtask

   task automatic test_out_of_range();
      applyStimulus(1'b1, 10'd1010, 32'h12345678, 4'hF, 1'b0, 10'd0);
      tick();
      checks++;
      if ({werrA, werrB} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL werr_pulse got %b want 11", {werrA, werrB});
      end
      idle();
      tick();
      checks++;
      if ({werrA, werrB} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL werr_clear got %b want 00", {werrA, werrB});
      end
      applyStimulus(1'b1, 10'd1010, 32'h12345678, 4'h0, 1'b0, 10'd0);
      tick();
      checks++;
      if ({werrA, werrB} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL werr_be0 got %b want 00", {werrA, werrB});
      end
      applyStimulus(1'b1, 10'd5, 32'h00000000, 4'h0, 1'b0, 10'd0);
      tick();
      applyStimulus(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd5);
      tick();
      checks++;
      if ({dvalidA, doutA} !== {1'b1, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL be0_noop_A got %h want %h", {dvalidA, doutA}, {1'b1, 32'hDEADBEEF});
      end
      applyStimulus(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd1010);
      tick();
      checks++;
      if ({dvalidA, rerrA, doutA} !== {1'b1, 1'b1, 32'h0}) begin
         errors++;
         $display("[TB] FAIL rerr_A got %h want %h", {dvalidA, rerrA, doutA}, {1'b1, 1'b1, 32'h0});
      end
      idle();
      tick();
      checks++;
      if ({dvalidB, rerrB, doutB} !== {1'b1, 1'b1, 32'h0}) begin
         errors++;
         $display("[TB] FAIL rerr_B got %h want %h", {dvalidB, rerrB, doutB}, {1'b1, 1'b1, 32'h0});
      end
      checks++;
      if ({dvalidA, rerrA} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL rerr_A_clear got %b want 00", {dvalidA, rerrA});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] expA [5];
      logic        vA   [5];
      logic [31:0] expB [5];
      logic        vB   [5];
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 10'(i), 32'hA0A0A000 + 32'(i), 4'hF, 1'b0, 10'd0);
         tick();
      end
      expA = '{32'hA0A0A000, 32'hA0A0A001, 32'hA0A0A002, 32'hA0A0A002, 32'hA0A0A002};
      vA   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      expB = '{32'h0, 32'hA0A0A000, 32'hA0A0A001, 32'hA0A0A002, 32'hA0A0A002};
      vB   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 5; c++) begin
         if (c < 3) applyStimulus(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'(c));
         else idle();
         tick();
         checks++;
         if (dvalidA !== vA[c] || (vA[c] && doutA !== expA[c])) begin
            errors++;
            $display("[TB] FAIL b2b_A cycle %0d got v=%b d=%h want v=%b d=%h", c, dvalidA, doutA, vA[c], expA[c]);
         end
         checks++;
         if (dvalidB !== vB[c] || (vB[c] && doutB !== expB[c])) begin
            errors++;
            $display("[TB] FAIL b2b_B cycle %0d got v=%b d=%h want v=%b d=%h", c, dvalidB, doutB, vB[c], expB[c]);
         end
      end
   endtask

   task automatic test_reset_in_flight();
      applyStimulus(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd5);
      tick();
      rst = 1'b1;
      applyStimulus(1'b1, 10'd5, 32'h00000000, 4'hF, 1'b0, 10'd0);
      #1;
      checks++;
      if ({dvalidA, rerrA, werrA, doutA, dvalidB, rerrB, werrB, doutB} !== 70'h0) begin
         errors++;
         $display("[TB] FAIL rst_async got A=%h B=%h want 0", {dvalidA, rerrA, werrA, doutA}, {dvalidB, rerrB, werrB, doutB});
      end
      tick();
      checks++;
      if (dvalidB !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_flush_B dvalid got %b want 0", dvalidB);
      end
      rst = 1'b0;
      idle();
      tick();
      checks++;
      if ({dvalidA, dvalidB} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL rst_after dvalid got %b want 00", {dvalidA, dvalidB});
      end
      applyStimulus(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd5);
      tick();
      checks++;
      if ({dvalidA, doutA} !== {1'b1, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL retain_A got %h want %h", {dvalidA, doutA}, {1'b1, 32'hDEADBEEF});
      end
      checks++;
      if (dvalidB !== 1'b0) begin
         errors++;
         $display("[TB] FAIL retain_B_early dvalid got %b want 0", dvalidB);
      end
      idle();
      tick();
      checks++;
      if ({dvalidB, doutB} !== {1'b1, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL retain_B got %h want %h", {dvalidB, doutB}, {1'b1, 32'hDEADBEEF});
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_bypass();
      test_out_of_range();
      test_back_to_back();
      test_reset_in_flight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rl_ram_1r1w_pipe.md
RL_RAM_1R1W_PIPE -- requirements
Module: rl_ram_1r1w_pipe

Interface
REQ-001 SHALL have parameter ABITS, 10, address width in bits.
REQ-002 SHALL have parameter DBITS, 32, data width in bits.
REQ-003 SHALL have parameter BBITS, 8, byte-lane width; lane count NB = (DBITS+BBITS-1)/BBITS.
REQ-004 SHALL have parameter DEPTH, 2**ABITS, number of words; legal range 1..2**ABITS.
REQ-005 SHALL have parameter RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
REQ-006 SHALL have parameter BYPASS, 1, same-address read-during-write mode: 1 = new data, 0 = old data.
REQ-007 SHALL have parameter INIT_FILE, "", hex initialisation file; empty means no initialisation.
REQ-008 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-009 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-010 SHALL have port waddr_i  input  ABITS  write address.
REQ-011 SHALL have port din_i  input  DBITS  write data.
REQ-012 SHALL have port we_i  input  1  write enable.
REQ-013 SHALL have port be_i  input  NB  byte-lane write enables.
REQ-014 SHALL have port raddr_i  input  ABITS  read address.
REQ-015 SHALL have port re_i  input  1  read enable.
REQ-016 SHALL have port dout_o  output  DBITS  read data.
REQ-017 SHALL have port dvalid_o  output  1  dout_o carries the result of a read this cycle.
REQ-018 SHALL have port rerr_o  output  1  the read presented on dout_o addressed a word >= DEPTH.
REQ-019 SHALL have port werr_o  output  1  one-cycle pulse: the previous cycle's write addressed a word >= DEPTH.

Function
REQ-020 SHALL write on the rising edge of clk_i when we_i=1, rst_i=0 and waddr_i<DEPTH; only lanes with be_i[n]=1 are updated.
REQ-021 SHALL, when DBITS is not a multiple of BBITS, treat the top lane as DBITS-(NB-1)*BBITS bits wide.
REQ-022 SHALL ignore a write with waddr_i>=DEPTH, leave memory unchanged, and assert werr_o for exactly the following cycle.
REQ-023 SHALL treat we_i=1 with be_i=0 as a no-op: no memory change and no werr_o.
REQ-024 SHALL sample raddr_i when re_i=1; with RD_LATENCY=1, dout_o/dvalid_o/rerr_o SHALL present the result on the next edge; with RD_LATENCY=2, one edge later.
REQ-025 SHALL accept one read per cycle, fully pipelined; back-to-back reads produce back-to-back dvalid_o.
REQ-026 SHALL hold dout_o at its last value and drive dvalid_o=0 and rerr_o=0 in cycles that carry no read result.
REQ-027 SHALL, for a read with raddr_i>=DEPTH, return dout_o=0 with dvalid_o=1 and rerr_o=1 in the same cycle.
REQ-028 SHALL, when re_i and we_i target the same in-range address in the same cycle with BYPASS=1, return din_i in enabled lanes and prior contents in disabled lanes.
REQ-029 SHALL, in the same-address case with BYPASS=0, return the complete prior word.
REQ-030 SHALL, with RD_LATENCY=2, make reads independent of writes in the cycle after the read is sampled.
REQ-031 SHALL, when INIT_FILE is non-empty, load memory contents from it at time zero; otherwise contents are undefined until written.
REQ-032 SHALL have no combinational path from any input to any output.

Reset
REQ-033 SHALL, while rst_i=1, asynchronously force dout_o=0, dvalid_o=0, rerr_o=0, werr_o=0, and clear all read-pipeline valid stages.
REQ-034 SHALL ignore writes presented while rst_i=1.
REQ-035 SHALL not reset memory contents; words written before reset SHALL retain their values.
REQ-036 SHALL discard, with no dvalid_o, any read in flight when rst_i asserts; the first read accepted after deassertion completes with normal latency.

Verification
REQ-037 SHALL cover: RD_LATENCY=1; write 0xDEADBEEF to address 5 with be_i=0xF, then read 5 -> dout_o=0xDEADBEEF, dvalid_o=1 one cycle after re_i.
REQ-038 SHALL cover: word 3=0x11223344; write 0xAABBCCDD to 3 with be_i=0x5, then read 3 -> 0x11BB33DD.
REQ-039 SHALL cover: word 7=0x00000000; same-cycle re/we to 7 with din_i=0xCAFEF00D and be_i=0xF -> BYPASS=1 returns 0xCAFEF00D; BYPASS=0 returns 0x00000000.
REQ-040 SHALL cover: DEPTH=1000, ABITS=10; write 1010 -> werr_o pulses one cycle and memory is unchanged; read 1010 -> dout_o=0, dvalid_o=1, rerr_o=1.
REQ-041 SHALL cover: RD_LATENCY=2; reads to 0,1,2 on consecutive cycles -> three consecutive dvalid_o cycles starting two cycles after the first re_i, data in order.
REQ-042 SHALL cover: rst_i asserted one cycle after re_i with RD_LATENCY=2 -> outputs zero immediately, no dvalid_o for that read, and previously written word 5 still reads 0xDEADBEEF after reset.
